// File: rtl/top_ncc_accumulator_pkg.sv
// Shared sizing and types for the NCC correlation accumulator.
// Line sums hold LINE_SIZE full-scale products; accumulators hold NUM_OF_LINES such sums.
package top_ncc_accumulator_pkg;

    localparam int unsigned PIXEL_SIZE    = 8;
    localparam int unsigned LINE_SIZE     = 8;
    localparam int unsigned NUM_TEMPLATES = 4;
    localparam int unsigned NUM_OF_LINES  = 8;

    localparam int unsigned PROD_W = 2 * PIXEL_SIZE;
    localparam int unsigned LS_W   = $clog2(LINE_SIZE) + PROD_W;
    localparam int unsigned ACC_W  = $clog2(NUM_OF_LINES) + LS_W;

    typedef logic [PIXEL_SIZE-1:0] pixel_t;
    typedef logic [PROD_W-1:0]     prod_t;
    typedef logic [LS_W-1:0]       ls_t;
    typedef logic [ACC_W-1:0]      acc_t;

    typedef pixel_t line_t [LINE_SIZE];
    typedef pixel_t tmpl_line_t [LINE_SIZE][NUM_TEMPLATES];

    function automatic acc_t widen(input ls_t v);
        return ACC_W'(v);
    endfunction

endpackage

// File: rtl/top_ncc_accumulator_if.sv
// Line-in / totals-out bundle between the line producer and the accumulator.
interface top_ncc_accumulator_if;
    import top_ncc_accumulator_pkg::*;

    pixel_t I_in_line [LINE_SIZE];
    pixel_t T_in_line [LINE_SIZE][NUM_TEMPLATES];
    acc_t   Acc_lines_sum_I_square;
    acc_t   Acc_lines_sum_I;
    acc_t   Acc_lines_sum_T_x_I_out_top [NUM_TEMPLATES];

    modport master (
        output I_in_line, T_in_line,
        input  Acc_lines_sum_I_square, Acc_lines_sum_I, Acc_lines_sum_T_x_I_out_top
    );

    modport slave (
        input  I_in_line, T_in_line,
        output Acc_lines_sum_I_square, Acc_lines_sum_I, Acc_lines_sum_T_x_I_out_top
    );
endinterface

// File: rtl/top_ncc_accumulator_line_sum_unit.sv
// Combinational per-line sums: sum of I, sum of I^2 and sum of T_k*I for each template.
module line_sum_unit
    import top_ncc_accumulator_pkg::*;
(
    input  pixel_t i_line [LINE_SIZE],
    input  pixel_t t_line [LINE_SIZE][NUM_TEMPLATES],
    output ls_t    s_i,
    output ls_t    s_i2,
    output ls_t    s_ti [NUM_TEMPLATES]
);

    prod_t sq   [LINE_SIZE];
    prod_t tprd [LINE_SIZE][NUM_TEMPLATES];

    always_comb begin
        for (int unsigned j = 0; j < LINE_SIZE; j++) begin
            sq[j] = prod_t'(i_line[j]) * prod_t'(i_line[j]);
            for (int unsigned k = 0; k < NUM_TEMPLATES; k++) begin
                tprd[j][k] = prod_t'(t_line[j][k]) * prod_t'(i_line[j]);
            end
        end
    end

    always_comb begin
        s_i  = '0;
        s_i2 = '0;
        for (int unsigned k = 0; k < NUM_TEMPLATES; k++) begin
            s_ti[k] = '0;
        end
        for (int unsigned j = 0; j < LINE_SIZE; j++) begin
            s_i  = s_i + LS_W'(i_line[j]);
            s_i2 = s_i2 + LS_W'(sq[j]);
            for (int unsigned k = 0; k < NUM_TEMPLATES; k++) begin
                s_ti[k] = s_ti[k] + LS_W'(tprd[j][k]);
            end
        end
    end

endmodule

// File: rtl/top_ncc_accumulator.sv
// NCC front end: registers one line's sums per clock and accumulates them across the window.
// Totals wrap modulo 2^ACC_W past NUM_OF_LINES full-scale lines; reset frames each window.
module top_ncc_accumulator
    import top_ncc_accumulator_pkg::*;
(
    input  logic                   CLK,
    input  logic                   reset,
    top_ncc_accumulator_if.slave   bus
);

    ls_t  s_i, s_i2;
    ls_t  s_ti [NUM_TEMPLATES];
    ls_t  s_i_q, s_i2_q;
    ls_t  s_ti_q [NUM_TEMPLATES];
    acc_t acc_i, acc_i2;
    acc_t acc_ti [NUM_TEMPLATES];

    line_sum_unit u_line_sum (
        .i_line (bus.I_in_line),
        .t_line (bus.T_in_line),
        .s_i    (s_i),
        .s_i2   (s_i2),
        .s_ti   (s_ti)
    );

    // Clearing the line stage too drops any line in flight when reset hits mid-window.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            s_i_q  <= '0;
            s_i2_q <= '0;
            acc_i  <= '0;
            acc_i2 <= '0;
            for (int unsigned k = 0; k < NUM_TEMPLATES; k++) begin
                s_ti_q[k] <= '0;
                acc_ti[k] <= '0;
            end
        end else begin
            s_i_q  <= s_i;
            s_i2_q <= s_i2;
            acc_i  <= acc_i + widen(s_i_q);
            acc_i2 <= acc_i2 + widen(s_i2_q);
            for (int unsigned k = 0; k < NUM_TEMPLATES; k++) begin
                s_ti_q[k] <= s_ti[k];
                acc_ti[k] <= acc_ti[k] + widen(s_ti_q[k]);
            end
        end
    end

    assign bus.Acc_lines_sum_I             = acc_i;
    assign bus.Acc_lines_sum_I_square      = acc_i2;
    assign bus.Acc_lines_sum_T_x_I_out_top = acc_ti;

endmodule

// File: tb/tb_top_ncc_accumulator.sv
// Self-checking bench for top_ncc_accumulator: directed table, async reset cases, random vs model.
module tb_top_ncc_accumulator;
    import top_ncc_accumulator_pkg::*;

    logic CLK;
    logic reset;

    top_ncc_accumulator_if bus ();

    top_ncc_accumulator dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        longint si;
        longint si2;
        longint sti [NUM_TEMPLATES];
    } sums_t;

    typedef struct {
        string       name;
        int          i_val;   // -1 selects I[j] = j
        int          t_val;   // -1 selects T[j][k] = k
        int unsigned hold;    // lines carrying the pattern, zeros afterwards
        int unsigned edges;   // clock edges before checking
        sums_t       exp;
    } vec_t;

    localparam longint MASK = (longint'(1) << ACC_W) - 1;

    sums_t       hist [$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    vec_t        vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input sums_t e);
        check({tag, "_sumI"}, 64'(bus.Acc_lines_sum_I), e.si);
        check({tag, "_sumI2"}, 64'(bus.Acc_lines_sum_I_square), e.si2);
        for (int k = 0; k < NUM_TEMPLATES; k++)
            check($sformatf("%s_sumTI%0d", tag, k), 64'(bus.Acc_lines_sum_T_x_I_out_top[k]), e.sti[k]);
    endtask

    function automatic sums_t zero_sums();
        sums_t z;
        z.si  = 0;
        z.si2 = 0;
        for (int k = 0; k < NUM_TEMPLATES; k++) z.sti[k] = 0;
        return z;
    endfunction

    // Record the line the DUT samples at this edge, straight from the driven inputs.
    task automatic model_push();
        sums_t s;
        s = zero_sums();
        for (int j = 0; j < LINE_SIZE; j++) begin
            longint iv;
            iv = longint'(bus.I_in_line[j]);
            s.si  += iv;
            s.si2 += iv * iv;
            for (int k = 0; k < NUM_TEMPLATES; k++)
                s.sti[k] += longint'(bus.T_in_line[j][k]) * iv;
        end
        hist.push_back(s);
    endtask

    // Two-cycle latency: every recorded line except the newest is in the totals.
    function automatic sums_t model_expect();
        sums_t e;
        e = zero_sums();
        for (int n = 0; n + 1 < hist.size(); n++) begin
            e.si  += hist[n].si;
            e.si2 += hist[n].si2;
            for (int k = 0; k < NUM_TEMPLATES; k++) e.sti[k] += hist[n].sti[k];
        end
        e.si  &= MASK;
        e.si2 &= MASK;
        for (int k = 0; k < NUM_TEMPLATES; k++) e.sti[k] &= MASK;
        return e;
    endfunction

    task automatic drive_pattern(input int iv, input int tv);
        for (int j = 0; j < LINE_SIZE; j++) begin
            bus.I_in_line[j] = (iv < 0) ? pixel_t'(j) : pixel_t'(iv);
            for (int k = 0; k < NUM_TEMPLATES; k++)
                bus.T_in_line[j][k] = (tv < 0) ? pixel_t'(k) : pixel_t'(tv);
        end
    endtask

    task automatic drive_random();
        for (int j = 0; j < LINE_SIZE; j++) begin
            bus.I_in_line[j] = pixel_t'($urandom_range(0, 255));
            for (int k = 0; k < NUM_TEMPLATES; k++)
                bus.T_in_line[j][k] = pixel_t'($urandom_range(0, 255));
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        hist.delete();
    endtask

    function automatic vec_t mk(input string name, input int iv, input int tv,
                                input int unsigned hold, input int unsigned edges,
                                input longint si, input longint si2,
                                input longint t0, input longint t1,
                                input longint t2, input longint t3);
        vec_t v;
        v.name  = name;
        v.i_val = iv;
        v.t_val = tv;
        v.hold  = hold;
        v.edges = edges;
        v.exp.si  = si;
        v.exp.si2 = si2;
        v.exp.sti[0] = t0;
        v.exp.sti[1] = t1;
        v.exp.sti[2] = t2;
        v.exp.sti[3] = t3;
        return v;
    endfunction

    initial begin
        vecs[0] = mk("const_e2",    1,   2, 100, 2,    8,       8,      16,      16,      16,      16);
        vecs[1] = mk("const_e5",    1,   2, 100, 5,   32,      32,      64,      64,      64,      64);
        vecs[2] = mk("worst_1line", 255, 255, 1, 2, 2040,  520200,  520200,  520200,  520200,  520200);
        vecs[3] = mk("worst_hold",  255, 255, 1, 6, 2040,  520200,  520200,  520200,  520200,  520200);
        vecs[4] = mk("tmpl_sep",    -1,  -1,  1, 2,   28,     140,       0,      28,      56,      84);
        vecs[5] = mk("cap_8",       255, 255, 8, 9, 16320, 4161600, 4161600, 4161600, 4161600, 4161600);
        vecs[6] = mk("wrap_9",      255, 255, 9, 10, 18360, 487496,  487496,  487496,  487496,  487496);

        reset = 1'b1;
        drive_pattern(0, 0);
        #2;
        check_all("reset_state", zero_sums());

        foreach (vecs[n]) begin
            do_reset();
            drive_pattern(vecs[n].i_val, vecs[n].t_val);
            for (int unsigned e = 1; e <= vecs[n].edges; e++) begin
                @(posedge CLK);
                model_push();
                #1;
                if (e >= vecs[n].hold) drive_pattern(0, 0);
            end
            check_all(vecs[n].name, vecs[n].exp);
            check_all({vecs[n].name, "_model"}, model_expect());
        end

        // Asynchronous reset between edges clears totals immediately and holds them at zero.
        do_reset();
        drive_pattern(1, 2);
        repeat (3) begin
            @(posedge CLK);
            model_push();
        end
        #3;
        reset = 1'b1;
        #1;
        check_all("async_rst_now", zero_sums());
        @(posedge CLK);
        #1;
        check_all("async_rst_held", zero_sums());
        @(negedge CLK);
        reset = 1'b0;
        hist.delete();

        // Random lines with a half-cycle reset pulse at cycle 5.
        for (int c = 0; c < 20; c++) begin
            drive_random();
            @(posedge CLK);
            model_push();
            #1;
            check_all($sformatf("rand_c%0d", c), model_expect());
            if (c == 5) begin
                #2;
                reset = 1'b1;
                #1;
                check_all("rand_rst", zero_sums());
                #4;
                reset = 1'b0;
                hist.delete();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
